// File: rtl/amiq_rs_fec_err_inject_stream.sv
// Streaming RS codeword error injector. Symbols pass through a single output
// register stage; corruption positions and values are fully deterministic
// (offset/stride schedule plus a seeded 16-bit Galois LFSR, or a fixed-period
// bit-flip pattern), so a scoreboard can predict every corrupted symbol.
module amiq_rs_fec_err_inject_stream #(
  parameter int          SYMBOL_SIZE       = 10,
  parameter int          CODEWORD_LENGTH   = 544,
  parameter int          MAX_ERRORS        = 30,
  parameter logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           cfg_mode,
  input  logic [$clog2(MAX_ERRORS+1)-1:0]      cfg_nof_errors,
  input  logic [$clog2(CODEWORD_LENGTH)-1:0]   cfg_offset,
  input  logic [$clog2(CODEWORD_LENGTH)-1:0]   cfg_stride,
  input  logic [15:0]                          cfg_flip_period,
  input  logic [15:0]                          cfg_seed,
  input  logic                                 cfg_seed_load,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SYMBOL_SIZE-1:0]               in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SYMBOL_SIZE-1:0]               out_data,
  output logic                                 out_err,
  output logic                                 out_erasure,
  output logic                                 out_sop,
  output logic                                 out_eop,
  output logic                                 cw_done,
  output logic [$clog2(CODEWORD_LENGTH+1)-1:0] cw_err_count
);

  localparam int NE_W  = $clog2(MAX_ERRORS+1);
  localparam int IDX_W = $clog2(CODEWORD_LENGTH);
  localparam int POS_W = IDX_W + 1;
  localparam int CNT_W = $clog2(CODEWORD_LENGTH+1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_ERR_NUM  = 2'd1,
    MODE_BIT_FLIP = 2'd2,
    MODE_ERASURE  = 2'd3
  } mode_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // LFSR replicated across the symbol; a zero pattern would be a silent error.
  function automatic logic [SYMBOL_SIZE-1:0] err_value(input logic [15:0] l);
    logic [SYMBOL_SIZE-1:0] e;
    for (int b = 0; b < SYMBOL_SIZE; b++) e[b] = l[b % 16];
    if (e == '0) e = {{(SYMBOL_SIZE-1){1'b0}}, 1'b1};
    return e;
  endfunction

  function automatic logic [NE_W-1:0] clamp_errors(input logic [NE_W-1:0] n);
    if (int'(n) > MAX_ERRORS) return NE_W'(MAX_ERRORS);
    return n;
  endfunction

  function automatic logic [15:0] eff_period(input logic [15:0] p);
    if (int'(p) < SYMBOL_SIZE) return 16'(SYMBOL_SIZE);
    return p;
  endfunction

  logic [IDX_W-1:0] idx;
  logic [15:0]      lfsr;
  logic [15:0]      bit_cnt;
  logic [POS_W-1:0] next_pos;
  logic [NE_W-1:0]  remaining;
  mode_t            mode_q;
  logic [IDX_W-1:0] stride_q;
  logic [15:0]      period_q;
  logic [CNT_W-1:0] run_cnt;

  logic             accept;
  logic             sop_p0, eop_p0;
  mode_t            mode_p0;
  logic [IDX_W-1:0] stride_p0;
  logic [15:0]      period_p0;
  logic [POS_W-1:0] pos_p0;
  logic [NE_W-1:0]  rem_p0;
  logic [15:0]      cnt_p0;
  logic [16:0]      bit_sum_p0;
  logic [15:0]      flip_bit_p0;
  logic             pos_hit_p0, flip_hit_p0;
  logic [SYMBOL_SIZE-1:0] flip_mask_p0, data_p0;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage p0: decide corruption for the symbol being accepted. At sop the
  // live cfg_* values are used directly so the first symbol already sees them.
  assign sop_p0      = (idx == '0);
  assign eop_p0      = (idx == IDX_W'(CODEWORD_LENGTH-1));
  assign mode_p0     = sop_p0 ? mode_t'(cfg_mode) : mode_q;
  assign stride_p0   = sop_p0 ? ((cfg_stride == '0) ? IDX_W'(1) : cfg_stride) : stride_q;
  assign period_p0   = sop_p0 ? eff_period(cfg_flip_period) : period_q;
  assign pos_p0      = sop_p0 ? {1'b0, cfg_offset} : next_pos;
  assign rem_p0      = sop_p0 ? clamp_errors(cfg_nof_errors) : remaining;
  assign cnt_p0      = sop_p0 ? 16'h0000 : bit_cnt;
  assign pos_hit_p0  = ((mode_p0 == MODE_ERR_NUM) || (mode_p0 == MODE_ERASURE)) &&
                       (rem_p0 != '0) && ({1'b0, idx} == pos_p0);
  assign bit_sum_p0  = {1'b0, cnt_p0} + 17'(SYMBOL_SIZE);
  assign flip_hit_p0 = (mode_p0 == MODE_BIT_FLIP) && (bit_sum_p0 >= {1'b0, period_p0});
  assign flip_bit_p0 = period_p0 - 16'd1 - cnt_p0;
  assign flip_mask_p0 = {{(SYMBOL_SIZE-1){1'b0}}, 1'b1} << flip_bit_p0;
  assign data_p0     = in_data ^ (pos_hit_p0  ? err_value(lfsr) :
                                  flip_hit_p0 ? flip_mask_p0    : '0);

  // Framing index, per-codeword config latch and error-schedule bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      mode_q    <= MODE_PASS;
      stride_q  <= IDX_W'(1);
      period_q  <= 16'(SYMBOL_SIZE);
      next_pos  <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      idx <= eop_p0 ? '0 : idx + IDX_W'(1);
      if (sop_p0) begin
        mode_q   <= mode_p0;
        stride_q <= stride_p0;
        period_q <= period_p0;
      end
      if (pos_hit_p0) begin
        next_pos  <= pos_p0 + {1'b0, stride_p0};
        remaining <= rem_p0 - NE_W'(1);
      end else if (sop_p0) begin
        next_pos  <= pos_p0;
        remaining <= rem_p0;
      end
      if (mode_p0 == MODE_BIT_FLIP)
        bit_cnt <= flip_hit_p0 ? bit_sum_p0[15:0] - period_p0 : bit_sum_p0[15:0];
      else
        bit_cnt <= '0;
    end
  end

  // LFSR: reload wins over an advance on a corrupted symbol in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= LFSR_SEED_DEFAULT;
    else if (cfg_seed_load)
      lfsr <= (cfg_seed == 16'h0000) ? LFSR_SEED_DEFAULT : cfg_seed;
    else if (accept && pos_hit_p0)
      lfsr <= lfsr_step(lfsr);
  end

  // Stage p1: output register, held while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_erasure <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= data_p0;
      out_err     <= pos_hit_p0 || flip_hit_p0;
      out_erasure <= pos_hit_p0 && (mode_p0 == MODE_ERASURE);
      out_sop     <= sop_p0;
      out_eop     <= eop_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-codeword corrupted-symbol statistics, counted at the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt      <= '0;
      cw_err_count <= '0;
      cw_done      <= 1'b0;
    end else begin
      cw_done <= out_valid && out_ready && out_eop;
      if (out_valid && out_ready) begin
        run_cnt <= (out_sop ? '0 : run_cnt) + CNT_W'(out_err);
        if (out_eop)
          cw_err_count <= (out_sop ? '0 : run_cnt) + CNT_W'(out_err);
      end
    end
  end

endmodule

// File: tb/tb_amiq_rs_fec_err_inject_stream.sv
// Directed bench for the streaming RS error injector.
module tb_amiq_rs_fec_err_inject_stream;

  localparam int S  = 10;
  localparam int N  = 544;
  localparam int ME = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_nof_errors;
  logic [9:0]  cfg_offset;
  logic [9:0]  cfg_stride;
  logic [15:0] cfg_flip_period;
  logic [15:0] cfg_seed;
  logic        cfg_seed_load;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_err;
  logic        out_erasure;
  logic        out_sop;
  logic        out_eop;
  logic        cw_done;
  logic [9:0]  cw_err_count;

  amiq_rs_fec_err_inject_stream #(
    .SYMBOL_SIZE(S), .CODEWORD_LENGTH(N), .MAX_ERRORS(ME), .LFSR_SEED_DEFAULT(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_nof_errors(cfg_nof_errors),
    .cfg_offset(cfg_offset), .cfg_stride(cfg_stride), .cfg_flip_period(cfg_flip_period),
    .cfg_seed(cfg_seed), .cfg_seed_load(cfg_seed_load), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .out_erasure(out_erasure), .out_sop(out_sop),
    .out_eop(out_eop), .cw_done(cw_done), .cw_err_count(cw_err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [9:0] cap_data [0:2*N-1];
  logic       cap_err  [0:2*N-1];
  logic       cap_ers  [0:2*N-1];
  logic       cap_sop  [0:2*N-1];
  logic       cap_eop  [0:2*N-1];
  int ncap, ndone, stall_bad, done_gap_bad;

  logic [9:0] exp_xor [0:N-1];
  logic       exp_err [0:N-1];
  logic       exp_ers [0:N-1];
  logic       exp_any [0:N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) begin
      exp_xor[i] = '0; exp_err[i] = 1'b0; exp_ers[i] = 1'b0; exp_any[i] = 1'b0;
    end
  endtask

  task automatic set_err(input int pos, input logic [9:0] x, input bit erasure);
    exp_xor[pos] = x; exp_err[pos] = 1'b1; exp_ers[pos] = erasure;
  endtask

  task automatic load_seed(input logic [15:0] s);
    cfg_seed = s; cfg_seed_load = 1'b1;
    @(posedge clk); #1;
    cfg_seed_load = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [4:0] ne, input logic [9:0] off,
                         input logic [9:0] str, input logic [15:0] per);
    cfg_mode = m; cfg_nof_errors = ne; cfg_offset = off; cfg_stride = str; cfg_flip_period = per;
  endtask

  // Drives ramp symbols (value = index within codeword) and captures output handshakes.
  task automatic run(input string tag, input int n_send, input bit bp, input bit stop_at_send);
    int  sent = 0;
    int  cyc = 0;
    int  last_eop_cyc = -10;
    int  budget = 4 * n_send + 100;
    bit  acc;
    bit  have_stall = 1'b0;
    logic [9:0] stall_data = '0;
    ncap = 0; ndone = 0; stall_bad = 0; done_gap_bad = 0;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(negedge clk);
      if (have_stall && (!out_valid || out_data !== stall_data)) stall_bad++;
      have_stall = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (ncap < 2*N) begin
          cap_data[ncap] = out_data; cap_err[ncap] = out_err; cap_ers[ncap] = out_erasure;
          cap_sop[ncap]  = out_sop;  cap_eop[ncap] = out_eop;
        end
        if (out_eop) last_eop_cyc = cyc;
        ncap++;
      end
      if (cw_done === 1'b1) begin
        ndone++;
        if (cyc != last_eop_cyc + 1) done_gap_bad++;
      end
      acc = in_valid && in_ready;
      if (!stop_at_send && ncap >= n_send && cyc == last_eop_cyc + 1) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      in_valid  = (sent < n_send);
      in_data   = 10'(sent % N);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stop_at_send && sent == n_send) break;
      if (cyc > budget) begin
        chk({tag, "_timeout_captured"}, ncap, n_send);
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_cw(input string tag, input int base, input int cnt);
    int mism = 0;
    int first = -1;
    logic [9:0] x;
    bit ok;
    for (int i = 0; i < cnt; i++) begin
      x  = cap_data[base+i] ^ 10'(i);
      ok = exp_any[i] ? (x !== 10'd0 && !$isunknown(x)) : (x === exp_xor[i]);
      ok = ok && (cap_err[base+i] === exp_err[i]) && (cap_ers[base+i] === exp_ers[i]) &&
           (cap_sop[base+i] === (i == 0)) && (cap_eop[base+i] === (i == N-1));
      if (!ok) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_symbols_first_bad_%0d", tag, first), mism, 0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_flags"}, {out_err, out_erasure, out_sop, out_eop}, 0);
    chk({tag, "_cw_done"}, cw_done, 0);
    chk({tag, "_cw_err_count"}, cw_err_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_seed = '0; cfg_seed_load = 1'b0;
    set_cfg(2'd0, 5'd0, 10'd0, 10'd1, 16'd16);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0: transparent pass-through.
    clear_exp();
    run("pass", N, 1'b0, 1'b0);
    check_cw("pass", 0, N);
    chk("pass_cw_err_count", cw_err_count, 0);
    chk("pass_cw_done_count", ndone, 1);
    chk("pass_cw_done_timing", done_gap_bad, 0);

    // Mode 1: 4 errors at 10,110,210,310; LFSR from seed 1 gives 1,1(zero->1),0x200,0x100.
    set_cfg(2'd1, 5'd4, 10'd10, 10'd100, 16'd16);
    load_seed(16'h0001);
    clear_exp();
    set_err(10, 10'h001, 0); set_err(110, 10'h001, 0);
    set_err(210, 10'h200, 0); set_err(310, 10'h100, 0);
    run("errnum", N, 1'b0, 1'b0);
    check_cw("errnum", 0, N);
    chk("errnum_sym210", cap_data[210], 10'(210) ^ 10'h200);
    chk("errnum_sym310", cap_data[310], 10'(310) ^ 10'h100);
    chk("errnum_cw_err_count", cw_err_count, 4);
    chk("errnum_cw_done_timing", done_gap_bad, 0);

    // Mode 1: positions past the codeword end are dropped (560 lost).
    set_cfg(2'd1, 5'd8, 10'd500, 10'd20, 16'd16);
    load_seed(16'h0001);
    clear_exp();
    set_err(500, 10'h001, 0); set_err(520, 10'h001, 0); set_err(540, 10'h200, 0);
    run("drop", N, 1'b0, 1'b0);
    check_cw("drop", 0, N);
    chk("drop_cw_err_count", cw_err_count, 3);

    // Mode 1: 31 requested clamps to 30; stride 0 acts as 1.
    set_cfg(2'd1, 5'd31, 10'd0, 10'd0, 16'd16);
    load_seed(16'h0001);
    clear_exp();
    for (int i = 0; i < ME; i++) begin
      exp_err[i] = 1'b1; exp_any[i] = 1'b1;
    end
    run("clamp", N, 1'b0, 1'b0);
    check_cw("clamp", 0, N);
    chk("clamp_cw_err_count", cw_err_count, ME);

    // Mode 3: identical corruption to the mode 1 case, erasure on each error.
    set_cfg(2'd3, 5'd4, 10'd10, 10'd100, 16'd16);
    load_seed(16'h0001);
    clear_exp();
    set_err(10, 10'h001, 1); set_err(110, 10'h001, 1);
    set_err(210, 10'h200, 1); set_err(310, 10'h100, 1);
    run("erasure", N, 1'b0, 1'b0);
    check_cw("erasure", 0, N);
    chk("erasure_cw_err_count", cw_err_count, 4);

    // Mode 2: period 25 flips global bit 25k+24 of each codeword; two codewords.
    set_cfg(2'd2, 5'd0, 10'd0, 10'd1, 16'd25);
    clear_exp();
    for (int j = 0; j < N; j++)
      for (int q = 0; q < S; q++)
        if ((S*j + q + 1) % 25 == 0) begin
          exp_xor[j] = 10'(1) << q; exp_err[j] = 1'b1;
        end
    run("flip", 2*N, 1'b0, 1'b0);
    check_cw("flip_cw0", 0, N);
    check_cw("flip_cw1", N, N);
    chk("flip_sym2", cap_data[2], 10'(2) ^ 10'h010);
    chk("flip_sym4", cap_data[4], 10'(4) ^ 10'h200);
    chk("flip_sym7", cap_data[7], 10'(7) ^ 10'h010);
    chk("flip_cw1_sym0", cap_data[N], 0);
    chk("flip_cw1_sym2", cap_data[N+2], 10'(2) ^ 10'h010);
    chk("flip_cw_err_count", cw_err_count, 217);
    chk("flip_cw_done_count", ndone, 2);

    // Backpressure, then reset mid-codeword after 300 accepted symbols.
    set_cfg(2'd1, 5'd4, 10'd10, 10'd100, 16'd16);
    load_seed(16'h0001);
    clear_exp();
    set_err(10, 10'h001, 0); set_err(110, 10'h001, 0);
    set_err(210, 10'h200, 0); set_err(310, 10'h100, 0);
    run("bp_pre", 300, 1'b1, 1'b1);
    chk("bp_pre_len", (ncap == 299 || ncap == 300), 1);
    check_cw("bp_pre", 0, ncap);
    chk("bp_pre_stall_stable", stall_bad, 0);
    rst = 1'b1;
    check_reset_state("midreset");
    rst = 1'b0;
    @(posedge clk); #1;

    // After reset LFSR is 0xACE1, so symbol 0 is corrupted by 0x0E1.
    set_cfg(2'd1, 5'd1, 10'd0, 10'd1, 16'd16);
    clear_exp();
    set_err(0, 10'h0E1, 0);
    run("bp_post", N, 1'b1, 1'b0);
    check_cw("bp_post", 0, N);
    chk("bp_post_first_sop", cap_sop[0], 1);
    chk("bp_post_first_data", cap_data[0], 10'h0E1);
    chk("bp_post_stall_stable", stall_bad, 0);
    chk("bp_post_cw_err_count", cw_err_count, 1);
    chk("bp_post_cw_done_count", ndone, 1);
    chk("bp_post_cw_done_timing", done_gap_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
